// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and sign-mode decode for the muldiv unit
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FAST = 3'd3;
  localparam logic [2:0] ST_FIX  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // {rs1 signed, rs2 signed}
  function automatic logic [1:0] sign_mode(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: sign_mode = 2'b11;
      OP_MULHSU:                       sign_mode = 2'b10;
      default:                         sign_mode = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_param_if.sv
// rtl/muldiv_unit_param_if.sv - request/response handshake bundle of the muldiv unit
interface muldiv_unit_param_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  num1_i;
  logic [XLEN-1:0]  num2_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport master (
    output in_valid_i, op_i, num1_i, num2_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_i, num1_i, num2_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - unsigned restoring divider retiring DIV_RBITS quotient bits per cycle
module iter_divider #(
  parameter int XLEN      = 32,
  parameter int DIV_RBITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int STEPS = XLEN / DIV_RBITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic [XLEN:0]   rem_q, rem_n;
  logic [XLEN-1:0] quo_q, quo_n, dsr_q;
  logic [CW-1:0]   cnt_q;

  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    for (int i = 0; i < DIV_RBITS; i++) begin
      rem_n = {rem_n[XLEN-1:0], quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (rem_n >= {1'b0, dsr_q}) begin
        rem_n    = rem_n - {1'b0, dsr_q};
        quo_n[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= CW'(STEPS);
      busy  <= 1'b1;
    end else if (busy) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy <= 1'b0;
    end
  end

  // done marks the cycle whose edge retires the final bits
  assign done      = busy && (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q[XLEN-1:0];
endmodule

// File: rtl/muldiv_unit_param.sv
// rtl/muldiv_unit_param.sv - multi-cycle RV M-extension unit with fast paths, reuse cache and flush
module muldiv_unit_param
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_LAT   = 3,
  parameter int DIV_RBITS = 2,
  parameter int TAG_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  muldiv_unit_param_if.slave bus
);
  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  logic [2:0]       state_q, op_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  num1_q, num2_q, a_q, b_q, res_q;
  logic             neg1_q, negp_q;
  logic [MCW-1:0]   mcnt_q;
  logic             cache_vld_q, cache_sgn_q;
  logic [XLEN-1:0]  cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

  logic [1:0]      smode;
  logic            neg1, neg2, accept, div_zero, div_ovf, cache_hit, fast;
  logic [XLEN-1:0] abs1, abs2;

  always_comb begin
    smode     = sign_mode(bus.op_i);
    neg1      = smode[1] & bus.num1_i[XLEN-1];
    neg2      = smode[0] & bus.num2_i[XLEN-1];
    abs1      = neg1 ? -bus.num1_i : bus.num1_i;
    abs2      = neg2 ? -bus.num2_i : bus.num2_i;
    accept    = (state_q == ST_IDLE) && bus.in_valid_i && !flush_i && !rst_i;
    div_zero  = (bus.num2_i == '0);
    div_ovf   = smode[0] && (bus.num1_i == INT_MIN) && (bus.num2_i == ALL_ONES);
    cache_hit = cache_vld_q && (cache_a_q == bus.num1_i) && (cache_b_q == bus.num2_i)
                && (cache_sgn_q == smode[0]);
    fast      = bus.op_i[2] && (div_zero || div_ovf || cache_hit);
  end

  logic            div_start, div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  assign div_start = accept && bus.op_i[2] && !fast && !div_busy;

  iter_divider #(.XLEN(XLEN), .DIV_RBITS(DIV_RBITS)) u_div (
    .clk       (clk_i),
    .rst       (rst_i || flush_i),
    .start     (div_start),
    .dividend  (abs1),
    .divisor   (abs2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // free-running chain so synthesis may retime the multiply into DSP pipeline stages
  logic [2*XLEN-1:0] prod_q [MUL_LAT];
  always_ff @(posedge clk_i) begin
    prod_q[0] <= {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
    for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res, fast_res;

  always_comb begin
    prod_s = negp_q ? -prod_q[MUL_LAT-1] : prod_q[MUL_LAT-1];
    quo_s  = negp_q ? -div_quo : div_quo;
    rem_s  = neg1_q ? -div_rem : div_rem;
    if (op_q[2])               fix_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                         fix_res = prod_s[2*XLEN-1:XLEN];
    if (num2_q == '0)
      fast_res = op_q[1] ? num1_q : ALL_ONES;
    else if (!op_q[0] && (num1_q == INT_MIN) && (num2_q == ALL_ONES))
      fast_res = op_q[1] ? '0 : INT_MIN;
    else
      fast_res = op_q[1] ? cache_rem_q : cache_quo_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q     <= ST_IDLE;
      cache_vld_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q   <= bus.op_i;
          tag_q  <= bus.tag_i;
          num1_q <= bus.num1_i;
          num2_q <= bus.num2_i;
          a_q    <= abs1;
          b_q    <= abs2;
          neg1_q <= neg1;
          negp_q <= neg1 ^ neg2;
          mcnt_q <= '0;
          if (!bus.op_i[2]) state_q <= ST_MUL;
          else if (fast)    state_q <= ST_FAST;
          else              state_q <= ST_DIV;
        end
        ST_MUL: begin
          mcnt_q <= mcnt_q + 1'b1;
          if (mcnt_q == MCW'(MUL_LAT - 1)) state_q <= ST_FIX;
        end
        ST_DIV: if (div_done) state_q <= ST_FIX;
        ST_FAST: begin
          res_q   <= fast_res;
          state_q <= ST_DONE;
        end
        ST_FIX: begin
          res_q   <= fix_res;
          state_q <= ST_DONE;
          if (op_q[2]) begin
            cache_vld_q <= 1'b1;
            cache_a_q   <= num1_q;
            cache_b_q   <= num2_q;
            cache_sgn_q <= !op_q[0];
            cache_quo_q <= quo_s;
            cache_rem_q <= rem_s;
          end
        end
        ST_DONE: if (bus.out_ready_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.result_o    = (state_q == ST_DONE) ? res_q : '0;
  assign bus.tag_o       = (state_q == ST_DONE) ? tag_q : '0;
endmodule
